// File: rtl/flash_bus_arb_pkg.sv
// flash_bus_arb_pkg: shared types, idle pin values and counter widths for the flash bus arbiter
package flash_bus_arb_pkg;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GUARD} state_e;

  localparam logic       IDLE_NCE  = 1'b1;
  localparam logic       IDLE_SCLK = 1'b0;
  localparam logic [3:0] IDLE_SOUT = 4'h0;
  localparam logic       IDLE_OE   = 1'b0;
  localparam logic       IDLE_QPI  = 1'b0;

  localparam int GUARD_CNT_W = 16;
  localparam int TMO_CNT_W   = 17;

endpackage

// File: rtl/flash_bus_arb_mux.sv
// flash_bus_arb_mux: combinational owner-select mux driving the flash pins, idle values when no owner
module flash_bus_arb_mux
  import flash_bus_arb_pkg::*;
(
  input  logic       own_vld_i,
  input  logic       own_idx_i,
  input  logic [1:0] req_nce_i,
  input  logic [1:0] req_sclk_i,
  input  logic [7:0] req_sout_i,
  input  logic [1:0] req_oe_i,
  input  logic [1:0] req_qpi_i,
  output logic       flash_nce_o,
  output logic       flash_sclk_o,
  output logic [3:0] flash_sout_o,
  output logic       flash_oe_o,
  output logic       flash_bus_qpi_o,
  output logic       flash_selected_o
);

  // Route the owner's pin signals straight through so edges reach the pins with no added latency
  always_comb begin
    flash_nce_o      = own_vld_i ? req_nce_i[own_idx_i]              : IDLE_NCE;
    flash_sclk_o     = own_vld_i ? req_sclk_i[own_idx_i]             : IDLE_SCLK;
    flash_sout_o     = own_vld_i ? req_sout_i[{own_idx_i, 2'b00} +: 4] : IDLE_SOUT;
    flash_oe_o       = own_vld_i ? req_oe_i[own_idx_i]               : IDLE_OE;
    flash_bus_qpi_o  = own_vld_i ? req_qpi_i[own_idx_i]              : IDLE_QPI;
    flash_selected_o = own_vld_i;
  end

endmodule

// File: rtl/flash_bus_arb.sv
// flash_bus_arb: round-robin two-requester arbiter for the config-flash port with nCE-high guard gap
// Optional owner timeout enabled by defining FLASH_BUS_ARB_TIMEOUT_EN.
module flash_bus_arb
  import flash_bus_arb_pkg::*;
#(
  parameter int GUARD_CYCLES = 4
`ifdef FLASH_BUS_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 65536
`endif
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req_req,
  output logic [1:0] req_gnt,
  input  logic [1:0] req_nce,
  input  logic [1:0] req_sclk,
  input  logic [7:0] req_sout,
  input  logic [1:0] req_oe,
  input  logic [1:0] req_qpi,
  output logic [3:0] req_sin,
  output logic       flash_nce,
  output logic       flash_sclk,
  output logic       flash_oe,
  output logic       flash_bus_qpi,
  output logic [3:0] flash_sout,
  input  logic [3:0] flash_sin,
  output logic       flash_selected
`ifdef FLASH_BUS_ARB_TIMEOUT_EN
  ,
  output logic       timeout_err
`endif
);

  localparam logic [GUARD_CNT_W-1:0] GUARD_LOAD = GUARD_CNT_W'(GUARD_CYCLES - 1);

  state_e                 state_q;
  logic                   last_q;
  logic [GUARD_CNT_W-1:0] guard_q;
  logic [1:0]             gnt_q;
  logic                   own;
  logic                   own_idx;
  logic                   pick_idx;
  logic                   release_req;
  logic                   tmo_hit;
  logic                   may_grant;

  assign own         = state_q == OWN0 || state_q == OWN1;
  assign own_idx     = state_q == OWN1;
  // On a tie the requester that did not own last wins; otherwise the sole requester wins
  assign pick_idx    = &req_req ? ~last_q : req_req[1];
  assign release_req = !req_req[own_idx] && req_nce[own_idx];
  assign may_grant   = (state_q == IDLE || (state_q == GUARD && guard_q == '0)) && |req_req;
  assign req_gnt     = gnt_q;
  assign req_sin     = flash_sin;

  // Ownership FSM: grant, hold until nCE is high and the request is gone, then run the guard gap
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      guard_q <= '0;
      gnt_q   <= 2'b00;
    end else if (may_grant) begin
      state_q <= pick_idx ? OWN1 : OWN0;
      gnt_q   <= pick_idx ? 2'b10 : 2'b01;
      last_q  <= pick_idx;
    end else if (state_q == GUARD) begin
      if (guard_q == '0) state_q <= IDLE;
      else guard_q <= guard_q - 1'b1;
    end else if (own && (release_req || tmo_hit)) begin
      state_q <= GUARD;
      gnt_q   <= 2'b00;
      guard_q <= GUARD_LOAD;
    end
  end

`ifdef FLASH_BUS_ARB_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] tmo_q;
  logic [TMO_CNT_W-1:0] tmo_d;
  logic                 err_q;

  assign tmo_hit     = own && !req_nce[own_idx] && tmo_q == TMO_CNT_W'(TIMEOUT_CYCLES - 1);
  assign tmo_d       = (own && !req_nce[own_idx] && !tmo_hit) ? tmo_q + 1'b1 : '0;
  assign timeout_err = err_q;

  // Count consecutive owned nCE-low cycles; the error flag is sticky until reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_q | tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Reset forces the pins idle immediately, even in the middle of a transaction
  flash_bus_arb_mux u_mux (
    .own_vld_i       (rstn && own),
    .own_idx_i       (own_idx),
    .req_nce_i       (req_nce),
    .req_sclk_i      (req_sclk),
    .req_sout_i      (req_sout),
    .req_oe_i        (req_oe),
    .req_qpi_i       (req_qpi),
    .flash_nce_o     (flash_nce),
    .flash_sclk_o    (flash_sclk),
    .flash_sout_o    (flash_sout),
    .flash_oe_o      (flash_oe),
    .flash_bus_qpi_o (flash_bus_qpi),
    .flash_selected_o(flash_selected)
  );

endmodule

// File: doc/flash_bus_arb.md
# flash_bus_arb

Two-requester arbiter for the single SPI/QPI configuration-flash port, which is driven through USRMCLK plus the four flash data tristates. It lets the SoC flash controller (requester 0) and the JTAG-driven flash programmer (requester 1) share the port without corrupting each other's transactions. It enforces round-robin ownership, never cuts a transaction while nCE is low, and inserts a nCE-high guard gap between owners. It sits between the requesters and the flash pin logic in the FPGA top level.

## Interface
- GUARD_CYCLES, 4: clk cycles with nCE high and the bus idle between two owners (min 1).
- TIMEOUT_CYCLES, 65536: maximum nCE-low cycles per owner (exists only with FLASH_BUS_ARB_TIMEOUT_EN).
- clk  in  1  system clock (clk48m domain).
- rstn  in  1  reset, synchronous, active-low.
- req_req  in  2  per-requester ownership request, bit i = requester i.
- req_gnt  out  2  per-requester grant, one-hot or zero.
- req_nce  in  2  per-requester flash chip enable, active-low.
- req_sclk  in  2  per-requester flash clock.
- req_sout  in  8  per-requester data out, bits [4i+3:4i].
- req_oe  in  2  per-requester output enable.
- req_qpi  in  2  per-requester QPI bus mode.
- req_sin  out  4  flash_sin broadcast to both requesters; only meaningful to the owner.
- flash_nce, flash_sclk, flash_oe, flash_bus_qpi  out  1 each  to the pin logic.
- flash_sout  out  4  to the pin logic.
- flash_sin  in  4  from the pin logic.
- flash_selected  out  1  high while an owner holds the bus; drives USRMCLK tristate enable.
- timeout_err  out  1  sticky timeout flag (only with FLASH_BUS_ARB_TIMEOUT_EN).

## Operation
- States: IDLE, OWN0, OWN1, GUARD.
- Idle pin values in IDLE and GUARD: flash_nce=1, flash_sclk=0, flash_sout=0, flash_oe=0, flash_bus_qpi=0, flash_selected=0.
- In OWNi, all flash_* outputs follow requester i combinationally, and flash_selected=1.
- IDLE: if any request bit is high, go to OWNi. With one request, that requester wins. With two, the winner is the requester that is not `last`.
- `last` is a 1-bit register holding the most recent owner. It resets to 1, so requester 0 wins the first tie.
- OWNi: leave only when req_req[i]=0 and req_nce[i]=1 in the same cycle, then go to GUARD with a counter loaded to GUARD_CYCLES-1.
- OWNi: a request dropped while req_nce[i]=0 is held until nCE rises; no mid-transaction cut.
- GUARD: decrement the counter each cycle. At 0, apply the IDLE selection rule in the same cycle, going directly to OWNx if anything is pending, otherwise to IDLE.
- req_gnt[i] = (state==OWNi); it is registered and equals the state.
- Reset: state=IDLE, `last`=1, counter=0, req_gnt=0, timeout_err=0, and all flash_* outputs at idle values from the first cycle with rstn=0. This applies even mid-transaction.

## Timing
- Grant latency from IDLE: req_req[i] sampled high at edge N, req_gnt[i] high after edge N (one cycle).
- Release: req_req low with nCE high sampled at edge N. req_gnt drops and GUARD starts after edge N. The next grant appears after edge N+GUARD_CYCLES.
- Owner mux is combinational with zero added latency, so sclk/sout/oe/nCE edges reach the pins in the same cycle.
- Request rising while in GUARD: not granted before the guard expires.
- Requester re-requesting immediately after release with the other requester idle: granted again after the guard.

## Configuration
- FLASH_BUS_ARB_TIMEOUT_EN defined:
  - A 17-bit counter counts consecutive owner cycles with nCE=0.
  - On reaching TIMEOUT_CYCLES, ownership is revoked (go to GUARD, outputs forced to idle) and timeout_err is set.
  - timeout_err clears only on reset.
- FLASH_BUS_ARB_TIMEOUT_EN undefined: no counter, no timeout_err port, and ownership is unbounded.

## Structure
- Package flash_bus_arb_pkg holds:
  - the state enum (IDLE, OWN0, OWN1, GUARD);
  - the idle-value constants for nce/sclk/sout/oe/qpi;
  - the counter widths.
- Sub-module flash_bus_arb_mux: pure combinational owner-select mux (owner valid + index in, flash_* out, idle values when not valid). The top holds the FSM, the counters and `last`.

## Test plan
- Single request, GUARD_CYCLES=4: req0 rises at cycle 10.
  - gnt0 high at cycle 11; flash_selected=1; flash_nce follows req_nce[0].
  - req0 drops at cycle 30 with nce=1; gnt0 low at 31 and the bus is idle through cycle 34.
- Tie after reset: req0 and req1 rise together. gnt0 first; after release and guard, gnt1. A second simultaneous tie grants req0 again (alternation).
- Hold during transaction: req0 drops while req_nce[0]=0 for 20 more cycles.
  - gnt0 stays high until the cycle after nCE rises.
  - req1 (pending) is granted exactly GUARD_CYCLES later.
- Reset mid-transaction: rstn=0 while OWN1 with nce low.
  - Next cycle: gnt=0, flash_nce=1, flash_selected=0.
  - After rstn=1 with both requesting, req0 wins.
- Timeout (macro on, TIMEOUT_CYCLES=100): owner holds nce low 150 cycles.
  - Revoked at cycle 100; timeout_err=1, and it stays set after the other requester's grant.
- Macro off: same stimulus, and the grant holds for all 150 cycles.
